alu_exec_unit: RTL and testbench



---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_seq_shifter.sv | 46 ++++
 rtl/alu_exec_unit.sv | 161 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes shared with the ALU-control decoder,
// plus the execution-unit FSM state type.
package alu_pkg;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_SLT  = 3'd6;
  localparam logic [2:0] OP_SLL  = 3'd7;

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } alu_state_e;

endpackage

// File: rtl/alu_seq_shifter.sv
// alu_seq_shifter: one-bit-per-cycle left shifter for SLL.
// done pulses on the step where the count reaches zero.
module alu_seq_shifter #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
  input  logic             step,
  output logic             done,
  output logic [WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;

  assign acc_next = acc_q << 1;
  assign done     = step && (cnt_q == SHW'(1));

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load) begin
      acc_d = a;
      cnt_d = amt;
    end else if (step && cnt_q != '0) begin
      acc_d = acc_next;
      cnt_d = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked EX-stage ALU with iterative SLL.
// Define ALU_EXEC_OVF_EN to add the signed-overflow output.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
`ifdef ALU_EXEC_OVF_EN
  ,
  output logic             ovf
`endif
);

  alu_state_e       state_q, state_d;
  logic             ov_q, ov_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] alu_r, sum, diff;
  logic             alu_ovf;
  logic             accept, iter, load;
  logic             sh_done;
  logic [WIDTH-1:0] sh_acc;
  logic [SHW-1:0]   amt;

  assign amt = b[SHW-1:0];
  assign sum  = a + b;
  assign diff = a - b;

  assign in_ready = (state_q == ST_IDLE)
                 && (!ov_q || out_ready)
                 && !flush;
  assign accept = in_valid && in_ready;
  assign iter   = (op_sel == OP_SLL) && (amt != '0);
  assign load   = accept && iter;

  always_comb begin
    alu_r   = '0;
    alu_ovf = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_r   = sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1])
               && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r   = diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1])
               && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: alu_r = a & b;
      OP_OR:  alu_r = a | b;
      OP_XOR: alu_r = a ^ b;
      OP_SLT: alu_r = {{(WIDTH-1){1'b0}},
                       $signed(a) < $signed(b)};
      // only reached here with a zero shift amount
      OP_SLL: alu_r = a;
      default: alu_r = '0;
    endcase
  end

  alu_seq_shifter #(
    .WIDTH(WIDTH),
    .SHW  (SHW)
  ) u_shift (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .load    (load),
    .a       (a),
    .amt     (amt),
    .step    (state_q == ST_SHIFT),
    .done    (sh_done),
    .acc_next(sh_acc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (load) state_d = ST_SHIFT;
      ST_SHIFT: if (sh_done) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

`ifdef ALU_EXEC_OVF_EN
  logic ovf_q, ovf_d;
  assign ovf = ovf_q;
`endif

  always_comb begin
    ov_d   = ov_q;
    res_d  = res_q;
    zero_d = zero_q;
`ifdef ALU_EXEC_OVF_EN
    ovf_d  = ovf_q;
`endif
    if (flush) begin
      ov_d = 1'b0;
    end else if (accept && !iter) begin
      ov_d   = 1'b1;
      res_d  = alu_r;
      zero_d = (alu_r == '0);
`ifdef ALU_EXEC_OVF_EN
      ovf_d  = alu_ovf;
`endif
    end else if (sh_done) begin
      ov_d   = 1'b1;
      res_d  = sh_acc;
      zero_d = (sh_acc == '0);
`ifdef ALU_EXEC_OVF_EN
      ovf_d  = 1'b0;
`endif
    end else if (out_ready) begin
      ov_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ov_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
`ifdef ALU_EXEC_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
`ifdef ALU_EXEC_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = ov_q;
  assign result    = res_q;
  assign zero      = zero_q;

`ifndef ALU_EXEC_OVF_EN
  logic unused_ovf;
  assign unused_ovf = alu_ovf;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed + random checks of alu_exec_unit
// against a transaction-level reference model.
module tb_alu_exec_unit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [2:0]  op_sel;
  logic [31:0] a, b, result;
  logic        out_valid, out_ready, zero;
`ifdef ALU_EXEC_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_sel   (op_sel),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero)
`ifdef ALU_EXEC_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h @%0t",
                  tag, got, exp, $time);
  endtask

  bit          m_init = 0;
  bit          m_held = 0;
  int          m_busy = 0;
  logic [31:0] m_val  = '0;
  logic [31:0] m_pend = '0;
  bit          m_ovf  = 0;
  bit          obs_rdy;

  function automatic logic [31:0] ref_res(
    input logic [2:0] op, input logic [31:0] x, y);
    case (op)
      3'd1: return x + y;
      3'd2: return x - y;
      3'd3: return x & y;
      3'd4: return x | y;
      3'd5: return x ^ y;
      3'd6: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd7: return x << y[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_ovf(
    input logic [2:0] op, input logic [31:0] x, y);
    longint sx, sy, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (op == 3'd1) r = sx + sy;
    else if (op == 3'd2) r = sx - sy;
    else return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  task automatic step(input bit rst, fl, v,
                      input logic [2:0] op,
                      input logic [31:0] aa, bb,
                      input bit ordy);
    bit exp_rdy, acc;
    int k;
    @(negedge clk);
    reset = rst; flush = fl; in_valid = v;
    op_sel = op; a = aa; b = bb; out_ready = ordy;
    #1;
    obs_rdy = in_ready;
    exp_rdy = (m_busy == 0) && (!m_held || ordy) && !fl;
    if (m_init) begin
      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_held);
      if (m_held) begin
        chk("result", result, m_val);
        chk("zero", zero, m_val == 0);
`ifdef ALU_EXEC_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
    @(posedge clk);
    acc = m_init && v && exp_rdy;
    if (rst) begin
      m_init = 1; m_held = 0; m_busy = 0;
    end else if (fl) begin
      m_held = 0; m_busy = 0;
    end else begin
      if (m_held && ordy) m_held = 0;
      if (acc) begin
        k = (op == 3'd7) ? int'(bb[4:0]) : 0;
        if (k == 0) begin
          m_held = 1;
          m_val  = ref_res(op, aa, bb);
          m_ovf  = ref_ovf(op, aa, bb);
        end else begin
          m_busy = k;
          m_pend = ref_res(op, aa, bb);
        end
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_held = 1; m_val = m_pend; m_ovf = 0;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input bit ordy);
    step(0, 0, 0, OP_NONE, 0, 0, ordy);
  endtask

  initial begin
    step(1, 0, 0, OP_NONE, 0, 0, 1);
    step(1, 0, 0, OP_NONE, 0, 0, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_zero", zero, 1);
`ifdef ALU_EXEC_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    idle(1);
    chk("rst_rdy", obs_rdy, 1);

    step(0, 0, 1, OP_ADD, 5, 7, 1);
    chk("add_ov", out_valid, 1);
    chk("add_res", result, 12);
    chk("add_zero", zero, 0);
    step(0, 0, 1, OP_SUB, 3, 5, 1);
    chk("sub_res", result, 32'hFFFF_FFFE);
    step(0, 0, 1, OP_SLT, 32'hFFFF_FFFF, 1, 1);
    chk("slt1_res", result, 1);
    step(0, 0, 1, OP_SLT, 1, 32'hFFFF_FFFF, 1);
    chk("slt0_res", result, 0);
    chk("slt0_zero", zero, 1);
    step(0, 0, 1, OP_NONE, 9, 9, 1);
    chk("none_res", result, 0);
    chk("none_zero", zero, 1);

    step(0, 0, 1, OP_SLL, 1, 4, 1);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      chk("sll_busy_rdy", obs_rdy, 0);
    end
    chk("sll_ov", out_valid, 1);
    chk("sll_res", result, 16);
    step(0, 0, 1, OP_SLL, 32'hABCD, 0, 1);
    chk("sll0_res", result, 32'hABCD);

    idle(1);
    step(0, 0, 1, OP_ADD, 5, 7, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, OP_ADD, 1, 1, 0);
      chk("hold_rdy", obs_rdy, 0);
      chk("hold_res", result, 12);
    end
    step(0, 0, 1, OP_ADD, 1, 1, 1);
    chk("rel_rdy", obs_rdy, 1);
    chk("rel_res", result, 2);

    idle(1);
    step(0, 0, 1, OP_SLL, 1, 20, 1);
    idle(1);
    idle(1);
    step(0, 1, 1, OP_ADD, 1, 1, 1);
    chk("fl_ov", out_valid, 0);
    idle(1);
    chk("fl_rdy", obs_rdy, 1);
    for (int i = 0; i < 25; i++) idle(1);
    chk("fl_never", out_valid, 0);

    step(0, 0, 1, OP_SLL, 1, 20, 1);
    idle(1);
    idle(1);
    step(1, 0, 0, OP_NONE, 0, 0, 1);
    chk("rs_ov", out_valid, 0);
    chk("rs_res", result, 0);
    chk("rs_zero", zero, 1);
    for (int i = 0; i < 25; i++) idle(1);
    chk("rs_never", out_valid, 0);

`ifdef ALU_EXEC_OVF_EN
    step(0, 0, 1, OP_ADD, 32'h7FFF_FFFF, 1, 1);
    chk("ovf_add_res", result, 32'h8000_0000);
    chk("ovf_add", ovf, 1);
    step(0, 0, 1, OP_SUB, 32'h8000_0000, 1, 1);
    chk("ovf_sub", ovf, 1);
    step(0, 0, 1, OP_AND, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    chk("ovf_and", ovf, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 1) == 0) rb = $urandom_range(0, 6);
      if ($urandom_range(0, 3) == 0) ra = ra & 32'h8000_0001;
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 3) != 0,
           3'($urandom_range(0, 7)),
           ra, rb,
           $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
